data_cache: RTL and testbench
=============================

DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, word width.
REQ-003 SHALL have parameter LINES, default 16, number of one-word lines; power of two, at least 2.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port cpu_req  in  1  CPU access valid; held stable until cpu_stall is low.
REQ-007 SHALL have port cpu_we  in  1  1 = store, 0 = load.
REQ-008 SHALL have ports cpu_addr  in  ADDR_W and cpu_wdata  in  DATA_W  access address and store data.
REQ-009 SHALL have port cpu_rdata  out  DATA_W  load data, valid when cpu_req & !cpu_we & !cpu_stall.
REQ-010 SHALL have port cpu_stall  out  1  CPU must hold its request this cycle.
REQ-011 SHALL have port flush  in  1  invalidate all lines.
REQ-012 SHALL have ports mem_req, mem_we  out  1  backing-memory request and write strobe.
REQ-013 SHALL have ports mem_addr  out  ADDR_W and mem_wdata  out  DATA_W  backing-memory address and data.
REQ-014 SHALL have ports mem_rdata  in  DATA_W and mem_ack  in  1  backing-memory read data and completion, any latency of 1 or more cycles.

Function
REQ-015 SHALL be direct-mapped: index = cpu_addr[log2(LINES)+1:2], tag = cpu_addr[ADDR_W-1:log2(LINES)+2], cpu_addr[1:0] ignored.
REQ-016 SHALL have the FSM states IDLE, RMISS and WTHRU.
REQ-017 SHALL serve a load hit in IDLE (valid & tag match) combinationally: cpu_rdata = line data, cpu_stall = 0, zero added latency.
REQ-018 SHALL, on a load miss in IDLE, drive cpu_stall = 1, latch the address and move to RMISS.
REQ-019 SHALL, in RMISS, drive mem_req = 1, mem_we = 0 and mem_addr = latched address; cpu_stall = !mem_ack.
REQ-020 SHALL, on mem_ack in RMISS, drive cpu_rdata = mem_rdata, fill the line (valid, tag, data) and return to IDLE.
REQ-021 SHALL, on a store in IDLE, drive cpu_stall = 1, latch the address and data and move to WTHRU; store is write-through, no-write-allocate.
REQ-022 SHALL, in WTHRU, drive mem_req = 1, mem_we = 1 with the latched address and data; cpu_stall = !mem_ack.
REQ-023 SHALL, on mem_ack in WTHRU, update the line data only if the line hit at latch time and still matches, then return to IDLE.
REQ-024 SHALL hold mem_addr, mem_wdata and mem_we stable while mem_req = 1; SHALL ignore mem_ack in IDLE.
REQ-025 SHALL, on flush in IDLE, clear all valid bits that cycle and drive cpu_stall = 1, serving any pending request on the next cycle.
REQ-026 SHALL defer a flush raised in RMISS or WTHRU until the return to IDLE, suppressing the RMISS fill when a flush is pending.
REQ-027 SHALL, with cpu_req = 0 in IDLE, drive cpu_stall = 0 and mem_req = 0.

Reset
REQ-028 SHALL, on reset assertion, go to IDLE, clear all valid bits and drive mem_req = 0, mem_we = 0, cpu_stall = 0 and cpu_rdata = 0; this aborts any outstanding memory access, including mid-RMISS or mid-WTHRU.
REQ-029 SHALL not reset the data and tag arrays.

Configuration
REQ-030 SHALL, with DATA_CACHE_STATS_EN defined, add outputs hit_count and miss_count (32 bits each, reset 0, wrap at 2^32-1 to 0), counting load hits and load misses once per accepted load.
REQ-031 SHALL, without DATA_CACHE_STATS_EN, have no counter ports or logic.

Verification
REQ-032 Bench SHALL cover: load 0x40 after reset with ack latency 3 -> stall for 4 cycles, cpu_rdata = mem_rdata (0xDEADBEEF); repeat load -> stall 0, same data, no mem_req.
REQ-033 Bench SHALL cover: store 0x40 = 0x12345678 on a hit line -> mem_req/mem_we for the latency, then a load of 0x40 hits with 0x12345678.
REQ-034 Bench SHALL cover: with LINES=16, load 0x40 then load 0x80 (same index, different tag) -> second load misses and evicts; reload of 0x40 misses.
REQ-035 Bench SHALL cover: flush raised during RMISS -> fill suppressed, data still returned; next load of the same address misses.
REQ-036 Bench SHALL cover: reset asserted mid-WTHRU -> mem_req falls asynchronously and all prior hits become misses.
REQ-037 Bench SHALL cover, with DATA_CACHE_STATS_EN: after REQ-032 -> hit_count = 1, miss_count = 1.

Source files
------------

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Optional hit/miss counters are enabled with DATA_CACHE_STATS_EN.
module data_cache #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINES  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              flush,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
`ifdef DATA_CACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int IW = $clog2(LINES);
  localparam int TW = ADDR_W - IW - 2;

  typedef enum logic [1:0] {IDLE, RMISS, WTHRU} state_t;
  state_t state, state_nx;

  logic [LINES-1:0]  valid;
  logic [TW-1:0]     tag_arr  [LINES];
  logic [DATA_W-1:0] data_arr [LINES];

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              whit_q;
  logic              flush_pend;

  logic [IW-1:0] idx, q_idx;
  logic [TW-1:0] tag, q_tag;
  logic          hit, q_match, flush_now;
  logic          idle_flush, idle_acc, ld_hit, ld_miss, st_acc;
  logic          ack_r, ack_w, fill;

  assign idx     = cpu_addr[IW+1:2];
  assign tag     = cpu_addr[ADDR_W-1:IW+2];
  assign q_idx   = addr_q[IW+1:2];
  assign q_tag   = addr_q[ADDR_W-1:IW+2];
  assign hit     = valid[idx] && (tag_arr[idx] == tag);
  assign q_match = valid[q_idx] && (tag_arr[q_idx] == q_tag);

  // A flush seen while busy is replayed on the first IDLE cycle.
  assign flush_now  = flush | flush_pend;
  assign idle_flush = (state == IDLE) && flush_now;
  assign idle_acc   = (state == IDLE) && !flush_now && cpu_req;
  assign ld_hit     = idle_acc && !cpu_we && hit;
  assign ld_miss    = idle_acc && !cpu_we && !hit;
  assign st_acc     = idle_acc && cpu_we;
  assign ack_r      = (state == RMISS) && mem_ack;
  assign ack_w      = (state == WTHRU) && mem_ack;
  assign fill       = ack_r && !flush_now;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      valid      <= '0;
      flush_pend <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      whit_q     <= 1'b0;
    end else begin
      state <= state_nx;
      if (idle_flush)      valid        <= '0;
      else if (fill)       valid[q_idx] <= 1'b1;
      if (idle_flush)                  flush_pend <= 1'b0;
      else if (state != IDLE && flush) flush_pend <= 1'b1;
      if (ld_miss || st_acc) addr_q <= cpu_addr;
      if (st_acc) begin
        wdata_q <= cpu_wdata;
        whit_q  <= hit;
      end
    end
  end

  // Tag and data storage carry no reset; valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_arr[q_idx]  <= q_tag;
      data_arr[q_idx] <= mem_rdata;
    end else if (ack_w && whit_q && q_match) begin
      data_arr[q_idx] <= wdata_q;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (ld_miss) state_nx = RMISS;
               else if (st_acc) state_nx = WTHRU;
      RMISS:   if (mem_ack) state_nx = IDLE;
      WTHRU:   if (mem_ack) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cpu_stall = 1'b0;
    cpu_rdata = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (flush_now) cpu_stall = 1'b1;
          else if (cpu_req) begin
            if (!cpu_we && hit) cpu_rdata = data_arr[idx];
            else                cpu_stall = 1'b1;
          end
        end
        RMISS: begin
          mem_req   = 1'b1;
          cpu_stall = !mem_ack;
          if (mem_ack) cpu_rdata = mem_rdata;
        end
        WTHRU: begin
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          cpu_stall = !mem_ack;
        end
        default: ;
      endcase
    end
  end

`ifdef DATA_CACHE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (ld_hit)  hit_count  <= hit_count + 32'd1;
      if (ld_miss) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: directed vector table, flush/reset corner sequences,
// and randomized traffic checked against a line-occupancy/memory model.
module tb_data_cache;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, flush = 1'b0, mem_ack = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, mem_rdata = '0;
  logic [31:0] cpu_rdata, mem_addr, mem_wdata;
  logic        cpu_stall, mem_req, mem_we;
`ifdef DATA_CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  data_cache #(.ADDR_W(32), .DATA_W(32), .LINES(16)) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall), .flush(flush), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
`ifdef DATA_CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int lat = 1;
  bit memseen, weseen;
  int mh = 0, mm = 0;
  logic [31:0] mem [int unsigned];
  logic [31:0] cline [int];

  function automatic logic [31:0] memdef(logic [31:0] wa);
    return (wa * 32'h01000193) ^ 32'h5bd1e995;
  endfunction

  function automatic logic [31:0] rd(logic [31:0] a);
    int unsigned wa = a >> 2;
    return mem.exists(wa) ? mem[wa] : memdef(a >> 2);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Backing memory: ack arrives after mem_req has been high for lat cycles.
  initial begin
    int cnt;
    logic [31:0] a0, w0;
    logic we0;
    cnt = 0; a0 = '0; w0 = '0; we0 = 1'b0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (mem_req) begin
        memseen = 1'b1;
        if (mem_we) weseen = 1'b1;
        cnt++;
        if (cnt == 1) begin a0 = mem_addr; w0 = mem_wdata; we0 = mem_we; end
        if (cnt == lat + 1) begin
          check("mem_addr_stable", mem_addr, a0);
          check("mem_we_stable", {31'd0, mem_we}, {31'd0, we0});
          if (mem_we) begin
            check("mem_wdata_stable", mem_wdata, w0);
            mem[mem_addr >> 2] = mem_wdata;
          end else mem_rdata = rd(mem_addr);
          mem_ack = 1'b1;
          cnt = 0;
        end
      end else cnt = 0;
    end
  end

  task automatic access(input bit we, input logic [31:0] a, input logic [31:0] wd, input int l,
                        output int stalls, output logic [31:0] rdv, output logic [1:0] saw);
    @(negedge clk);
    lat = l; memseen = 1'b0; weseen = 1'b0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    stalls = 0;
    #1;
    while (cpu_stall && stalls < 50) begin
      stalls++;
      @(negedge clk); #1;
    end
    if (stalls >= 50) begin
      tests++; fails++;
      $display("FAIL access_timeout: addr %h still stalled after %0d cycles, required release", a, stalls);
    end
    rdv = cpu_rdata;
    saw = {weseen, memseen};
    @(posedge clk); #2;
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    int          exp_stall;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_mem;
  } vec_t;
  vec_t tbl [10];

  initial begin
    int st;
    logic [31:0] rv, er;
    logic [1:0] sv;
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, l, r, idx;
    logic [31:0] rv, a, wd, er, wa;
    logic [1:0] sv;
    bit we, hm;

    mem[32'h40 >> 2] = 32'hDEADBEEF;
    mem[32'h80 >> 2] = 32'hCAFEF00D;
    tbl[0] = '{1'b0, 32'h40,  32'h0,        3, 4, 32'hDEADBEEF, 2'b01};
    tbl[1] = '{1'b0, 32'h40,  32'h0,        3, 0, 32'hDEADBEEF, 2'b00};
    tbl[2] = '{1'b1, 32'h40,  32'h12345678, 2, 3, 32'h0,        2'b11};
    tbl[3] = '{1'b0, 32'h40,  32'h0,        1, 0, 32'h12345678, 2'b00};
    tbl[4] = '{1'b0, 32'h80,  32'h0,        2, 3, 32'hCAFEF00D, 2'b01};
    tbl[5] = '{1'b0, 32'h40,  32'h0,        1, 2, 32'h12345678, 2'b01};
    tbl[6] = '{1'b0, 32'h44,  32'h0,        1, 2, memdef(32'h11), 2'b01};
    tbl[7] = '{1'b1, 32'h104, 32'hA5A5A5A5, 1, 2, 32'h0,        2'b11};
    tbl[8] = '{1'b0, 32'h44,  32'h0,        1, 0, memdef(32'h11), 2'b00};
    tbl[9] = '{1'b0, 32'h104, 32'h0,        4, 5, 32'hA5A5A5A5, 2'b01};

    repeat (2) @(negedge clk);
    #1;
    check("reset_mem_req", {31'd0, mem_req}, 32'd0);
    check("reset_mem_we", {31'd0, mem_we}, 32'd0);
    check("reset_stall", {31'd0, cpu_stall}, 32'd0);
    check("reset_rdata", cpu_rdata, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      access(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].lat, st, rv, sv);
      check($sformatf("vec%0d_stall", i), st, tbl[i].exp_stall);
      check($sformatf("vec%0d_mem", i), {30'd0, sv}, {30'd0, tbl[i].exp_mem});
      if (!tbl[i].we) begin
        check($sformatf("vec%0d_rdata", i), rv, tbl[i].exp_rdata);
        if (tbl[i].exp_mem == 2'b00) mh++; else mm++;
      end
`ifdef DATA_CACHE_STATS_EN
      if (i == 1) begin
        check("stats_hit_after_first_pair", hit_count, 32'd1);
        check("stats_miss_after_first_pair", miss_count, 32'd1);
      end
`endif
    end

    // Flush during a refill: data still returned, line not installed.
    fork
      access(1'b0, 32'h200, 32'h0, 3, st, rv, sv);
      begin
        repeat (2) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
      end
    join
    check("flush_rmiss_rdata", rv, rd(32'h200));
    check("flush_rmiss_mem", {30'd0, sv}, 32'd1);
    access(1'b0, 32'h200, 32'h0, 2, st, rv, sv);
    check("post_flush_miss", {30'd0, sv}, 32'd1);
    check("post_flush_rdata", rv, rd(32'h200));
    access(1'b0, 32'h200, 32'h0, 2, st, rv, sv);
    check("post_fill_hit_stall", st, 0);
    access(1'b0, 32'h104, 32'h0, 1, st, rv, sv);
    check("flush_cleared_other_line", {30'd0, sv}, 32'd1);
    mm += 3; mh += 1;
    cline.delete();
    cline[0] = 32'h200 >> 2;
    cline[1] = 32'h104 >> 2;

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        @(negedge clk);
        flush = 1'b1;
        #1 check("idle_flush_stall", {31'd0, cpu_stall}, 32'd1);
        @(negedge clk);
        flush = 1'b0;
        cline.delete();
      end else begin
        we  = (r < 7);
        idx = $urandom_range(0, 15);
        a   = ($urandom_range(0, 3) << 6) | (idx << 2) | $urandom_range(0, 3);
        l   = $urandom_range(1, 4);
        wd  = $urandom;
        wa  = a >> 2;
        hm  = cline.exists(idx) && (cline[idx] == wa);
        er  = rd(a);
        access(we, a, wd, l, st, rv, sv);
        if (we) begin
          check("rnd_store_stall", st, 1 + l);
          check("rnd_store_mem", {30'd0, sv}, 32'd3);
          check("rnd_store_memval", rd(a), wd);
        end else begin
          check("rnd_load_stall", st, hm ? 0 : 1 + l);
          check("rnd_load_mem", {30'd0, sv}, hm ? 32'd0 : 32'd1);
          check("rnd_load_rdata", rv, er);
          if (hm) mh++;
          else begin
            mm++;
            cline[idx] = wa;
          end
        end
      end
    end
`ifdef DATA_CACHE_STATS_EN
    check("stats_hit_random", hit_count, mh);
    check("stats_miss_random", miss_count, mm);
`endif

    // Reset in the middle of a write-through aborts it and invalidates everything.
    access(1'b0, 32'h40, 32'h0, 1, st, rv, sv);
    access(1'b0, 32'h40, 32'h0, 1, st, rv, sv);
    check("pre_reset_hit", st, 0);
    fork
      access(1'b1, 32'h44, 32'h77777777, 8, st, rv, sv);
      begin
        repeat (3) @(negedge clk);
        #3 reset = 1'b1;
        #1;
        check("async_reset_mem_req", {31'd0, mem_req}, 32'd0);
        check("async_reset_mem_we", {31'd0, mem_we}, 32'd0);
        check("async_reset_stall", {31'd0, cpu_stall}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
      end
    join
    access(1'b0, 32'h40, 32'h0, 2, st, rv, sv);
    check("post_reset_miss", {30'd0, sv}, 32'd1);
    check("post_reset_stall", st, 3);
    check("post_reset_rdata", rv, rd(32'h40));
`ifdef DATA_CACHE_STATS_EN
    check("stats_hit_after_reset", hit_count, 32'd0);
    check("stats_miss_after_reset", miss_count, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
